demux_tdm_1to8: RTL

DEMUX_TDM_1TO8 -- requirements
Module: demux_tdm_1to8

---
 rtl/demux_tdm_1to8_if.sv | 20 ++
 rtl/demux_tdm_1to8.sv | 61 ++++++
 2 files changed

// File: rtl/demux_tdm_1to8_if.sv
// demux_tdm_1to8_if: serial-in and parallel-out handshake bundle for demux_tdm_1to8.
interface demux_tdm_1to8_if;
    logic       din;
    logic       din_valid;
    logic       din_ready;
    logic       sync;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic [2:0] slot;
    logic       parity_err;
    modport master (
        output din, din_valid, sync, dout_ready,
        input  din_ready, dout, dout_valid, slot, parity_err
    );
    modport slave (
        input  din, din_valid, sync, dout_ready,
        output din_ready, dout, dout_valid, slot, parity_err
    );
endinterface

// File: rtl/demux_tdm_1to8.sv
// demux_tdm_1to8: TDM 1-to-8 serial demultiplexer with valid/ready on both sides.
// Define DEMUX_TDM_PARITY_EN for 9-slot frames whose last slot carries even parity.
module demux_tdm_1to8 #(
    parameter int LSB_FIRST = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    demux_tdm_1to8_if.slave bus
);
`ifdef DEMUX_TDM_PARITY_EN
    localparam logic [3:0] LAST = 4'd8;
`else
    localparam logic [3:0] LAST = 4'd7;
`endif
    logic [3:0] cnt;
    logic [7:0] asm_q;
    logic [7:0] word;
    logic [7:0] lanes;
    logic       accept;
    logic       load;
    assign bus.din_ready = !(cnt == LAST && bus.dout_valid && !bus.dout_ready);
    assign accept        = bus.din_valid && bus.din_ready;
    assign load          = accept && !bus.sync && cnt == LAST;
    assign bus.slot      = cnt[3] ? 3'd7 : cnt[2:0];
`ifdef DEMUX_TDM_PARITY_EN
    assign word = asm_q;
`else
    // lane 7 comes straight from din so the word completes on its final bit
    assign word = cnt == LAST ? {bus.din, asm_q[6:0]} : asm_q;
`endif
    always_comb begin
        lanes = '0;
        for (int i = 0; i < 8; i++) lanes[i] = LSB_FIRST != 0 ? word[i] : word[7 - i];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            asm_q          <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
        end else begin
            if (bus.sync) begin
                cnt   <= accept ? 4'd1 : 4'd0;
                asm_q <= accept ? {7'd0, bus.din} : 8'h00;
            end else if (accept) begin
                cnt <= cnt == LAST ? 4'd0 : cnt + 4'd1;
                if (!cnt[3]) asm_q[cnt[2:0]] <= bus.din;
            end
            if (load) bus.dout <= lanes;
            bus.dout_valid <= load || (bus.dout_valid && !bus.dout_ready);
        end
    end
`ifdef DEMUX_TDM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.parity_err <= 1'b0;
        else if (load) bus.parity_err <= ^{asm_q, bus.din};
    end
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule
